// File: rtl/datapath_ctrl_pkg.sv
// Shared constants, state encoding and control-word layout for the
// MIPS-subset datapath sequencer.
package datapath_ctrl_pkg;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0101;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt
  } state_e;

  typedef enum logic [2:0] {
    KindNone,
    KindAlu,
    KindLoad,
    KindStore,
    KindBranch,
    KindJump
  } kind_e;

  typedef struct packed {
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src;
    logic [3:0] alu_control;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
  } ctrl_t;

  localparam ctrl_t CtrlNone = '0;

  function automatic logic [31:0] branch_target(input logic [31:0] pc_plus4,
                                                input logic [15:0] imm);
    return pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode/funct decoder: execute-phase control word, legality
// and instruction class.
module instr_decoder
  import datapath_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output ctrl_t      ctrl,
  output logic       legal,
  output kind_e      kind
);

  always_comb begin
    ctrl  = CtrlNone;
    legal = 1'b1;
    kind  = KindNone;
    unique case (op)
      OpRtype: begin
        kind            = KindAlu;
        ctrl.reg_dst    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        unique case (funct)
          FnAdd:   ctrl.alu_control = AluAdd;
          FnSub:   ctrl.alu_control = AluSub;
          FnAnd:   ctrl.alu_control = AluAnd;
          FnOr:    ctrl.alu_control = AluOr;
          FnSlt:   ctrl.alu_control = AluSlt;
          default: begin
            ctrl  = CtrlNone;
            legal = 1'b0;
            kind  = KindNone;
          end
        endcase
      end
      OpAddi: begin
        kind             = KindAlu;
        ctrl.alu_src     = 1'b1;
        ctrl.alu_control = AluAdd;
        ctrl.mem_to_reg  = 1'b1;
        ctrl.reg_write   = 1'b1;
      end
      OpSw: begin
        kind             = KindStore;
        ctrl.alu_src     = 1'b1;
        ctrl.alu_control = AluAdd;
        ctrl.mem_write   = 1'b1;
      end
      OpLw: begin
        kind             = KindLoad;
        ctrl.alu_src     = 1'b1;
        ctrl.alu_control = AluAdd;
        ctrl.mem_read    = 1'b1;
      end
      OpBeq: begin
        kind             = KindBranch;
        ctrl.alu_control = AluSub;
      end
      OpJ: begin
        kind = KindJump;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle sequencer: fetches from instruction memory, latches IR and
// drives the datapath field/control inputs one execute sequence per instruction.
module datapath_sequencer
  import datapath_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_instr,
  input  logic        is0,
  output logic [5:0]  op,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic        RegDst,
  output logic        RegWrite,
  output logic        ALUSrc,
  output logic [3:0]  ALUcontrol,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic [31:0] pc,
  output logic        halted,
  output logic [31:0] instr_count
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] count_q, count_d;
  logic [31:0] pc_plus4;

  ctrl_t dec_ctrl;
  ctrl_t ctrl;
  logic  dec_legal;
  kind_e dec_kind;

  instr_decoder u_decoder (
    .op    (ir_q[31:26]),
    .funct (ir_q[5:0]),
    .ctrl  (dec_ctrl),
    .legal (dec_legal),
    .kind  (dec_kind)
  );

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    count_d  = count_q;
    ctrl     = CtrlNone;
    imem_req = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StFetch;
      end
      StFetch: begin
        imem_req = 1'b1;
        if (imem_valid) begin
          ir_d    = imem_instr;
          state_d = StDecode;
        end
      end
      StDecode: begin
        state_d = dec_legal ? StExec : StHalt;
      end
      StExec: begin
        ctrl = dec_ctrl;
        unique case (dec_kind)
          KindAlu, KindStore: begin
            pc_d    = pc_plus4;
            count_d = count_q + 32'd1;
            state_d = StFetch;
          end
          KindLoad: begin
            state_d = StMem;
          end
          KindBranch: begin
            pc_d    = is0 ? branch_target(pc_plus4, ir_q[15:0]) : pc_plus4;
            count_d = count_q + 32'd1;
            state_d = StFetch;
          end
          KindJump: begin
            pc_d    = {pc_plus4[31:28], ir_q[25:0], 2'b00};
            count_d = count_q + 32'd1;
            state_d = StFetch;
          end
          default: begin
            state_d = StHalt;
          end
        endcase
      end
      StMem: begin
        ctrl    = dec_ctrl;
        state_d = StWb;
      end
      StWb: begin
        // ADD is held so the load address stays valid while MemRead is high.
        ctrl.alu_src     = 1'b1;
        ctrl.alu_control = AluAdd;
        ctrl.mem_read    = 1'b1;
        ctrl.reg_write   = 1'b1;
        pc_d             = pc_plus4;
        count_d          = count_q + 32'd1;
        state_d          = StFetch;
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      count_q <= count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr_count = count_q;
  assign halted      = (state_q == StHalt);

  assign op    = ir_q[31:26];
  assign rs    = ir_q[25:21];
  assign rt    = ir_q[20:16];
  assign rd    = ir_q[15:11];
  assign shamt = ir_q[10:6];
  assign funct = ir_q[5:0];

  assign RegDst     = ctrl.reg_dst;
  assign RegWrite   = ctrl.reg_write;
  assign ALUSrc     = ctrl.alu_src;
  assign ALUcontrol = ctrl.alu_control;
  assign MemRead    = ctrl.mem_read;
  assign MemWrite   = ctrl.mem_write;
  assign MemtoReg   = ctrl.mem_to_reg;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Randomized self-checking bench for datapath_sequencer against a per-instruction
// reference model of expected control sequences, next PC and retire count.
module tb_datapath_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, imem_valid, is0;
  logic [31:0] imem_instr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic        RegDst, RegWrite, ALUSrc, MemRead, MemWrite, MemtoReg;
  logic [3:0]  ALUcontrol;
  logic [31:0] pc, instr_count;
  logic        halted;

  datapath_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .start(start), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_instr(imem_instr), .is0(is0), .op(op), .rs(rs), .rt(rt),
    .rd(rd), .shamt(shamt), .funct(funct), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrc(ALUSrc), .ALUcontrol(ALUcontrol), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .pc(pc), .halted(halted), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_pc, m_count, exp_next_pc;
  logic [9:0]  exp_seq[$];
  bit          exp_legal;
  logic [9:0]  ctrl_obs;

  assign ctrl_obs = {RegDst, RegWrite, ALUSrc, ALUcontrol, MemRead, MemWrite, MemtoReg};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] cw(input bit reg_dst, input bit reg_wr, input bit alu_src,
                                    input logic [3:0] alu, input bit mem_rd, input bit mem_wr,
                                    input bit m2r);
    return {reg_dst, reg_wr, alu_src, alu, mem_rd, mem_wr, m2r};
  endfunction

  // Expected per-cycle controls after DECODE, and resulting PC, from the ISA table.
  task automatic build_expect(input logic [31:0] instr, input bit z);
    logic [5:0]  o, f;
    logic [31:0] pc4, off;
    o = instr[31:26];
    f = instr[5:0];
    pc4 = m_pc + 32'd4;
    off = {{16{instr[15]}}, instr[15:0]} * 32'd4;
    exp_seq.delete();
    exp_legal = 1'b1;
    exp_next_pc = pc4;
    case (o)
      6'd0: begin
        case (f)
          6'd32: exp_seq.push_back(cw(1, 1, 0, 4'd5, 0, 0, 1));
          6'd34: exp_seq.push_back(cw(1, 1, 0, 4'd6, 0, 0, 1));
          6'd36: exp_seq.push_back(cw(1, 1, 0, 4'd0, 0, 0, 1));
          6'd37: exp_seq.push_back(cw(1, 1, 0, 4'd1, 0, 0, 1));
          6'd42: exp_seq.push_back(cw(1, 1, 0, 4'd7, 0, 0, 1));
          default: exp_legal = 1'b0;
        endcase
      end
      6'd8:  exp_seq.push_back(cw(0, 1, 1, 4'd5, 0, 0, 1));
      6'd43: exp_seq.push_back(cw(0, 0, 1, 4'd5, 0, 1, 0));
      6'd35: begin
        exp_seq.push_back(cw(0, 0, 1, 4'd5, 1, 0, 0));
        exp_seq.push_back(cw(0, 0, 1, 4'd5, 1, 0, 0));
        exp_seq.push_back(cw(0, 1, 1, 4'd5, 1, 0, 0));
      end
      6'd4: begin
        exp_seq.push_back(cw(0, 0, 0, 4'd6, 0, 0, 0));
        if (z) exp_next_pc = pc4 + off;
      end
      6'd2: begin
        exp_seq.push_back(10'd0);
        exp_next_pc = {pc4[31:28], instr[25:0], 2'b00};
      end
      default: exp_legal = 1'b0;
    endcase
  endtask

  // Starts with the DUT in FETCH; ends back in FETCH (or in HALT for illegal).
  task automatic run_instr(input logic [31:0] instr, input int delay, input bit z,
                           output int cycles);
    build_expect(instr, z);
    cycles = 0;
    is0 = z;
    imem_valid = 1'b0;
    for (int i = 0; i < delay; i++) begin
      imem_instr = $urandom;
      check_eq("wait_req", {31'd0, imem_req}, 32'd1);
      check_eq("wait_addr", imem_addr, m_pc);
      check_eq("wait_ctrl", {22'd0, ctrl_obs}, 32'd0);
      step();
      cycles++;
    end
    imem_instr = instr;
    imem_valid = 1'b1;
    check_eq("fetch_req", {31'd0, imem_req}, 32'd1);
    check_eq("fetch_addr", imem_addr, m_pc);
    step();
    cycles++;
    imem_valid = 1'($urandom_range(0, 1));
    imem_instr = $urandom;
    check_eq("decode_ctrl", {22'd0, ctrl_obs}, 32'd0);
    check_eq("fields", {op, rs, rt, rd, shamt, funct}, instr);
    step();
    cycles++;
    if (!exp_legal) begin
      imem_valid = 1'b0;
      check_eq("halt_flag", {31'd0, halted}, 32'd1);
      check_eq("halt_ctrl", {22'd0, ctrl_obs}, 32'd0);
      check_eq("halt_req", {31'd0, imem_req}, 32'd0);
      return;
    end
    foreach (exp_seq[i]) begin
      check_eq($sformatf("ctrl_op%0d_c%0d", instr[31:26], i), {22'd0, ctrl_obs},
               {22'd0, exp_seq[i]});
      step();
      cycles++;
    end
    imem_valid = 1'b0;
    m_pc = exp_next_pc;
    m_count = m_count + 32'd1;
    check_eq("pc", pc, m_pc);
    check_eq("count", instr_count, m_count);
    check_eq("refetch_req", {31'd0, imem_req}, 32'd1);
  endtask

  task automatic do_reset_and_start();
    rst = 1'b1;
    #1;
    check_eq("rst_pc", pc, 32'd0);
    check_eq("rst_req", {31'd0, imem_req}, 32'd0);
    step();
    rst = 1'b0;
    m_pc = 32'd0;
    m_count = 32'd0;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  a, b, c, s;
    logic [15:0] imm;
    logic [5:0]  fn;
    a = 5'($urandom);
    b = 5'($urandom);
    c = 5'($urandom);
    s = 5'($urandom);
    imm = 16'($urandom);
    case ($urandom_range(0, 4))
      0: fn = 6'd32;
      1: fn = 6'd34;
      2: fn = 6'd36;
      3: fn = 6'd37;
      default: fn = 6'd42;
    endcase
    case ($urandom_range(0, 5))
      0: return {6'd0, a, b, c, s, fn};
      1: return {6'd8, a, b, imm};
      2: return {6'd43, a, b, imm};
      3: return {6'd35, a, b, imm};
      4: return {6'd4, a, b, imm};
      default: return {6'd2, 26'($urandom)};
    endcase
  endfunction

  initial begin
    int cyc;
    rst = 1'b1;
    start = 1'b0;
    imem_valid = 1'b0;
    is0 = 1'b0;
    imem_instr = 32'd0;
    #2;
    check_eq("reset_pc", pc, 32'd0);
    check_eq("reset_count", instr_count, 32'd0);
    check_eq("reset_req", {31'd0, imem_req}, 32'd0);
    check_eq("reset_halted", {31'd0, halted}, 32'd0);
    check_eq("reset_ctrl", {22'd0, ctrl_obs}, 32'd0);
    check_eq("reset_fields", {op, rs, rt, rd, shamt, funct}, 32'd0);
    step();
    step();
    rst = 1'b0;
    m_pc = 32'd0;
    m_count = 32'd0;

    // IDLE ignores imem_valid until start.
    imem_valid = 1'b1;
    imem_instr = 32'h0043_0820;
    step();
    step();
    check_eq("idle_req", {31'd0, imem_req}, 32'd0);
    check_eq("idle_pc", pc, 32'd0);
    imem_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;

    run_instr(32'h0043_0820, 0, 1'b0, cyc);
    check_eq("add_latency", cyc, 32'd3);
    check_eq("add_pc", pc, 32'd4);
    run_instr(32'h8C44_0000, 0, 1'b0, cyc);
    check_eq("lw_latency", cyc, 32'd5);
    check_eq("lw_pc", pc, 32'd8);
    run_instr(32'h1022_0003, 0, 1'b1, cyc);
    check_eq("beq_taken_addr", imem_addr, 32'd24);

    do_reset_and_start();
    run_instr(32'h0043_0820, 0, 1'b0, cyc);
    run_instr(32'h8C44_0000, 0, 1'b1, cyc);
    run_instr(32'h1022_0003, 0, 1'b0, cyc);
    check_eq("beq_not_taken_addr", imem_addr, 32'd12);
    run_instr(32'h0043_0820, 4, 1'b1, cyc);
    check_eq("stall_latency", cyc, 32'd7);

    for (int n = 0; n < 250; n++) begin
      run_instr(rand_instr(), $urandom_range(0, 3), 1'($urandom_range(0, 1)), cyc);
    end

    // Illegal opcode: HALT is sticky until reset.
    run_instr({6'b111111, 26'($urandom)}, 1, 1'b0, cyc);
    for (int n = 0; n < 3; n++) begin
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      check_eq("halt_sticky", {31'd0, halted}, 32'd1);
      check_eq("halt_pc", pc, m_pc);
      check_eq("halt_ctrl_hold", {22'd0, ctrl_obs}, 32'd0);
    end
    rst = 1'b1;
    #1;
    rst = 1'b0;
    step();
    check_eq("post_halt_pc", pc, 32'd0);
    check_eq("post_halt_halted", {31'd0, halted}, 32'd0);
    check_eq("post_halt_idle_req", {31'd0, imem_req}, 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    m_pc = 32'd0;
    m_count = 32'd0;

    // Asynchronous reset in the lw WB cycle.
    run_instr(32'h0043_0820, 0, 1'b0, cyc);
    imem_instr = 32'h8C44_0000;
    imem_valid = 1'b1;
    step();
    imem_valid = 1'b0;
    step();
    step();
    step();
    check_eq("wb_regwrite", {31'd0, RegWrite}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_regwrite", {31'd0, RegWrite}, 32'd0);
    check_eq("async_ctrl", {22'd0, ctrl_obs}, 32'd0);
    check_eq("async_pc", pc, 32'd0);
    check_eq("async_count", instr_count, 32'd0);
    check_eq("async_fields", {op, rs, rt, rd, shamt, funct}, 32'd0);
    step();
    rst = 1'b0;
    step();
    check_eq("after_async_req", {31'd0, imem_req}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
